// File: rtl/simple_dram_responder_pkg.sv
// Shared request/response bundles and sizing constants
// for the simple DRAM responder.
package simple_dram_responder_pkg;

    localparam int DATA_WIDTH  = 512;
    localparam int ADDR_WIDTH  = 64;
    localparam int WORD_OFFSET = 6;

    typedef struct packed {
        logic                  valid;
        logic                  isWrite;
        logic [ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0] data;
    } MemReq;

    typedef struct packed {
        logic                  valid;
        logic [DATA_WIDTH-1:0] data;
    } MemResp;

endpackage

// File: rtl/simple_dram_responder_fifo.sv
// Register-based response queue; head is read straight
// from storage so it stays stable while not popped.
module simple_dram_responder_fifo #(
    parameter int WIDTH     = 512,
    parameter int LOG_DEPTH = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] pushData,
    input  logic             pop,
    output logic             empty,
    output logic [WIDTH-1:0] headData
);

    localparam int DEPTH = 2 ** LOG_DEPTH;

    logic [WIDTH-1:0]     store [DEPTH];
    logic [LOG_DEPTH-1:0] rdPtr;
    logic [LOG_DEPTH-1:0] wrPtr;
    logic [LOG_DEPTH:0]   count;
    logic                 full;

    assign empty    = (count == '0);
    assign full     = (count == (LOG_DEPTH+1)'(DEPTH));
    assign headData = store[rdPtr];

    always_ff @(posedge clk) begin
        if (rst) begin
            rdPtr <= '0;
            wrPtr <= '0;
            count <= '0;
        end else begin
            if (push) wrPtr <= wrPtr + 1'b1;
            if (pop)  rdPtr <= rdPtr + 1'b1;
            count <= count + (LOG_DEPTH+1)'(push)
                           - (LOG_DEPTH+1)'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push) store[wrPtr] <= pushData;
    end

    // Credit accounting upstream must keep these unreachable.
    noOverflow: assert property (
        @(posedge clk) disable iff (rst) !(push && full));
    noUnderflow: assert property (
        @(posedge clk) disable iff (rst) !(pop && empty));

endmodule

// File: rtl/simple_dram_responder.sv
// Block-RAM backed memory responder: writes are posted,
// reads return in order through a credit-managed queue.
module simple_dram_responder
    import simple_dram_responder_pkg::*;
#(
    parameter int LOG_DEPTH        = 10,
    parameter int READ_LATENCY     = 2,
    parameter int RESP_Q_LOG_DEPTH = 3
) (
    input  logic   clk,
    input  logic   rst,
    input  MemReq  reqIn,
    output logic   reqIn_grant,
    output MemResp respOut,
    input  logic   respOut_grant
);

    localparam int DEPTH   = 2 ** LOG_DEPTH;
    localparam int Q_DEPTH = 2 ** RESP_Q_LOG_DEPTH;
    localparam int HI_BIT  = WORD_OFFSET + LOG_DEPTH;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [DATA_WIDTH-1:0] pipeData [READ_LATENCY];
    logic                  pipeValid [READ_LATENCY];

    logic [LOG_DEPTH-1:0]      wordIdx;
    logic [RESP_Q_LOG_DEPTH:0] outstanding;
    logic                      readAccept;
    logic                      writeAccept;
    logic                      deq;
    logic                      qEmpty;
    logic [DATA_WIDTH-1:0]     qHead;
    logic                      unusedAddrBits;

    assign wordIdx = reqIn.addr[HI_BIT-1:WORD_OFFSET];
    assign unusedAddrBits =
        ^{reqIn.addr[ADDR_WIDTH-1:HI_BIT],
          reqIn.addr[WORD_OFFSET-1:0]};

    // Grant looks only at the registered credit count.
    assign reqIn_grant = !rst && (reqIn.isWrite ||
        outstanding < (RESP_Q_LOG_DEPTH+1)'(Q_DEPTH));

    assign writeAccept = reqIn.valid && reqIn_grant
                         && reqIn.isWrite;
    assign readAccept  = reqIn.valid && reqIn_grant
                         && !reqIn.isWrite;

    assign respOut.valid = !qEmpty && !rst;
    assign respOut.data  = qHead;
    assign deq           = respOut.valid && respOut_grant;

    always_ff @(posedge clk) begin
        if (writeAccept) mem[wordIdx] <= reqIn.data;
        if (readAccept)  pipeData[0] <= mem[wordIdx];
        for (int i = 1; i < READ_LATENCY; i++)
            pipeData[i] <= pipeData[i-1];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < READ_LATENCY; i++)
                pipeValid[i] <= 1'b0;
        end else begin
            pipeValid[0] <= readAccept;
            for (int i = 1; i < READ_LATENCY; i++)
                pipeValid[i] <= pipeValid[i-1];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            outstanding <= '0;
        end else if (readAccept && !deq) begin
            outstanding <= outstanding + 1'b1;
        end else if (!readAccept && deq) begin
            outstanding <= outstanding - 1'b1;
        end
    end

    simple_dram_responder_fifo #(
        .WIDTH     (DATA_WIDTH),
        .LOG_DEPTH (RESP_Q_LOG_DEPTH)
    ) respQ (
        .clk      (clk),
        .rst      (rst),
        .push     (pipeValid[READ_LATENCY-1]),
        .pushData (pipeData[READ_LATENCY-1]),
        .pop      (deq),
        .empty    (qEmpty),
        .headData (qHead)
    );

endmodule
